subleq_run_ctrl: RTL and testbench

- Run controller and memory owner for the subleq core. It sits between the core's shared bus (write/address/bidirectional data), a single-port asynchronous-read RAM, and a host port.
- While the core is stopped, the host owns the RAM: program load, result readback.
- On a start pulse it releases the core, gives it the RAM, counts instructions and detects halt, then stops the core and returns the RAM to the host.

---
 rtl/subleq_run_ctrl.sv | 118 +++++++++++
 tb/tb_subleq_run_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_run_ctrl.sv
// Run controller and RAM owner for the subleq core: host load/readback while stopped, core access while running.
// Optional watchdog (wdog_limit port, halted_by=3) is enabled by defining SUBLEQ_WDOG_EN.
module subleq_run_ctrl #(
    parameter int              BITS      = 8,
    parameter logic [BITS-1:0] HALT_ADDR = {BITS{1'b1}}
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stop,
    output logic            busy,
    output logic            done,
    output logic [1:0]      halted_by,
    output logic [BITS-1:0] insn_count,
    output logic            cpu_reset,
    input  logic            cpu_write,
    input  logic [BITS-1:0] cpu_address,
    inout  wire  [BITS-1:0] cpu_data,
    input  logic            host_valid,
    output logic            host_ready,
    input  logic            host_we,
    input  logic [BITS-1:0] host_addr,
    input  logic [BITS-1:0] host_wdata,
    output logic [BITS-1:0] host_rdata,
    output logic            mem_we,
    output logic [BITS-1:0] mem_addr,
    output logic [BITS-1:0] mem_wdata,
`ifdef SUBLEQ_WDOG_EN
    input  logic [BITS-1:0] wdog_limit,
`endif
    input  logic [BITS-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] HB_NONE = 2'd0;
    localparam logic [1:0] HB_HALT = 2'd1;
    localparam logic [1:0] HB_STOP = 2'd2;
    localparam logic [1:0] HB_WDOG = 2'd3;

    state_t          state;
    logic            run;
    logic            wr_d;
    logic [BITS-1:0] cnt_next;
    logic            halt_hit;
    logic            wdog_hit;

    function automatic logic [BITS-1:0] sat_inc(input logic [BITS-1:0] v);
        return (&v) ? v : v + {{(BITS-1){1'b0}}, 1'b1};
    endfunction

    assign run      = (state == RUN);
    assign cnt_next = (run && cpu_write) ? sat_inc(insn_count) : insn_count;
    // wr_d marks the cycle after a stage-3 write, i.e. the fetch of the new PC
    assign halt_hit = wr_d && (cpu_address == HALT_ADDR);

`ifdef SUBLEQ_WDOG_EN
    assign wdog_hit = (wdog_limit != '0) && (cnt_next >= wdog_limit);
`else
    assign wdog_hit = 1'b0;
`endif

    // RAM ownership: core while running, host otherwise
    assign mem_addr   = run ? cpu_address : host_addr;
    assign mem_we     = run ? cpu_write   : (host_valid & host_we);
    assign mem_wdata  = run ? cpu_data    : host_wdata;
    assign host_ready = !run;
    assign host_rdata = mem_rdata;
    assign cpu_data   = (run && !cpu_write) ? mem_rdata : {BITS{1'bz}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            halted_by  <= HB_NONE;
            insn_count <= '0;
            cpu_reset  <= 1'b1;
            wr_d       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        halted_by  <= HB_NONE;
                        insn_count <= '0;
                        cpu_reset  <= 1'b0;
                        wr_d       <= 1'b0;
                    end
                end
                RUN: begin
                    insn_count <= cnt_next;
                    wr_d       <= cpu_write;
                    if (stop || halt_hit || wdog_hit) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b1;
                        wr_d      <= 1'b0;
                        if (stop)          halted_by <= HB_STOP;
                        else if (halt_hit) halted_by <= HB_HALT;
                        else               halted_by <= HB_WDOG;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    cpu_reset <= 1'b1;
                    wr_d      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_run_ctrl.sv
// Directed bench for subleq_run_ctrl with a behavioural 4-stage subleq core and an async-read RAM.
module tb_subleq_run_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start, stop;
    logic       busy, done;
    logic [1:0] halted_by;
    logic [7:0] insn_count;
    logic       cpu_reset;
    logic       cpu_write;
    logic [7:0] cpu_address;
    wire  [7:0] cpu_data;
    logic       host_valid, host_ready, host_we;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef SUBLEQ_WDOG_EN
    logic [7:0] wdog_limit;
`endif

    int nvec = 0;
    int nerr = 0;
    int we_cnt = 0;

    subleq_run_ctrl #(.BITS(8), .HALT_ADDR(8'hFF)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
        .busy(busy), .done(done), .halted_by(halted_by), .insn_count(insn_count),
        .cpu_reset(cpu_reset), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_data(cpu_data), .host_valid(host_valid), .host_ready(host_ready),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
`ifdef SUBLEQ_WDOG_EN
        .wdog_limit(wdog_limit),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // RAM: asynchronous read, synchronous write
    logic [7:0] ram [256];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clock) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    // Core: stage 0 fetch a, 1 fetch b, 2 read mem[a], 3 write mem[b]-mem[a] and branch
    logic [1:0] stage;
    logic [7:0] pc, ca, cb, va, core_res, c_ptr, pc_next;
    logic       probe_en;
    assign core_res  = ram[cb] - va;
    assign c_ptr     = pc + 8'd2;
    assign pc_next   = ($signed(core_res) <= 0) ? ram[c_ptr] : pc + 8'd3;
    assign cpu_write = !cpu_reset && (stage == 2'd3);
    assign cpu_data  = cpu_write ? core_res : 8'hzz;
    assign cpu_data  = probe_en ? 8'hA5 : 8'hzz;

    always_comb begin
        cpu_address = pc;
        case (stage)
            2'd0: cpu_address = pc;
            2'd1: cpu_address = pc + 8'd1;
            2'd2: cpu_address = ca;
            default: cpu_address = cb;
        endcase
    end

    always @(posedge clock) begin
        if (cpu_reset) begin
            stage <= 2'd0;
            pc    <= 8'd0;
        end else begin
            case (stage)
                2'd0: ca <= cpu_data;
                2'd1: cb <= cpu_data;
                2'd2: va <= cpu_data;
                default: pc <= pc_next;
            endcase
            stage <= stage + 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        tick;
        host_valid = 1'b0; host_we = 1'b0;
    endtask

    int n, ready_bad, wc0;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; probe_en = 1'b0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = 8'h05; host_wdata = 8'h00;
`ifdef SUBLEQ_WDOG_EN
        wdog_limit = 8'd0;
`endif
        tick; tick;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_halted_by", halted_by, 0);
        chk("rst_insn_count", insn_count, 0);
        chk("rst_host_ready", host_ready, 1);
        probe_en = 1'b1; #1;
        chk("rst_cpu_data_z", cpu_data, 8'hA5);
        probe_en = 1'b0;
        reset_n = 1'b1;
        tick;

        // Host load and readback
        wc0 = we_cnt;
        host_write(8'h05, 8'h12);
        chk("host_we_pulses", we_cnt - wc0, 1);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h05; #1;
        chk("host_rdata", host_rdata, 8'h12);
        chk("host_ready_rd", host_ready, 1);
        chk("host_rd_no_we", mem_we, 0);
        host_valid = 1'b0;

        // Halt program: mem[7] = 3 - 5 = 0xFE <= 0, branch to 0xFF
        host_write(8'h00, 8'h06);
        host_write(8'h01, 8'h07);
        host_write(8'h02, 8'hFF);
        host_write(8'h06, 8'h05);
        host_write(8'h07, 8'h03);
        host_write(8'h20, 8'h00);
        start = 1'b1; tick; start = 1'b0;
        chk("halt_cpu_reset_rel", cpu_reset, 0);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'hAA;
        n = 0; ready_bad = 0;
        while (busy && n < 20) begin
            if (host_ready) ready_bad++;
            tick; n++;
        end
        chk("halt_busy_cycles", n, 5);
        chk("halt_host_ready_run", ready_bad, 0);
        chk("halt_host_blocked", ram[8'h20], 8'h00);
        chk("halt_done", done, 1);
        chk("halt_halted_by", halted_by, 1);
        chk("halt_insn_count", insn_count, 1);
        chk("halt_cpu_reset", cpu_reset, 1);
        chk("halt_host_ready", host_ready, 1);
        tick;
        chk("halt_host_after", ram[8'h20], 8'hAA);
        host_valid = 1'b0; host_we = 1'b0; host_addr = 8'h07; #1;
        chk("halt_result", host_rdata, 8'hFE);

        // Infinite loop: mem[6] = mem[6] - mem[6] = 0, branch to 0
        host_write(8'h01, 8'h06);
        host_write(8'h02, 8'h00);
        host_write(8'h06, 8'h09);
        start = 1'b1; tick; start = 1'b0;
        chk("loop_hb_cleared", halted_by, 0);
        chk("loop_done_cleared", done, 0);
        tick;
        chk("loop_cpu_data_rd", cpu_data, ram[cpu_address]);
        repeat (39) tick;
        chk("stop_pre_count", insn_count, 10);
        chk("stop_pre_busy", busy, 1);
        stop = 1'b1; tick; stop = 1'b0;
        chk("stop_done", done, 1);
        chk("stop_halted_by", halted_by, 2);
        chk("stop_insn_count", insn_count, 10);
        chk("stop_cpu_reset", cpu_reset, 1);
        chk("stop_busy", busy, 0);
        stop = 1'b1; tick; stop = 1'b0;
        chk("stop_in_done_ign", halted_by, 2);

        // start and stop together outside RUN: start wins
        start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 1);
        chk("startstop_hb", halted_by, 0);
        repeat (5) tick;
        chk("run_count_1", insn_count, 1);
        start = 1'b1; tick; start = 1'b0;
        chk("start_in_run_ign", insn_count, 1);
        repeat (1100) tick;
        chk("sat_count", insn_count, 8'hFF);
        chk("sat_busy", busy, 1);

        // Async reset mid-run
        host_addr = 8'h00;
        #2 reset_n = 1'b0; #1;
        chk("arst_cpu_reset", cpu_reset, 1);
        chk("arst_busy", busy, 0);
        chk("arst_host_ready", host_ready, 1);
        chk("arst_insn_count", insn_count, 0);
        probe_en = 1'b1; #1;
        chk("arst_cpu_data_z", cpu_data, 8'hA5);
        probe_en = 1'b0;
        reset_n = 1'b1;
        tick;
        chk("arst_ram_kept", host_rdata, 8'h06);

`ifdef SUBLEQ_WDOG_EN
        wdog_limit = 8'd3;
        start = 1'b1; tick; start = 1'b0;
        n = 0;
        while (busy && n < 50) begin tick; n++; end
        chk("wdog_cycles", n, 12);
        chk("wdog_halted_by", halted_by, 3);
        chk("wdog_insn_count", insn_count, 3);
        wdog_limit = 8'd0;
        start = 1'b1; tick; start = 1'b0;
        repeat (40) tick;
        chk("wdog_off_busy", busy, 1);
        stop = 1'b1; tick; stop = 1'b0;
        chk("wdog_off_stop", halted_by, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
